pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 39 +++
 rtl/pipe_ctrl_perf.sv | 32 +++
 rtl/pipe_ctrl.sv | 104 ++++++++++
 tb/tb_pipe_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared pipeline-control encodings (stall vectors, exception codes, vectors).
`default_nettype none

package pipe_ctrl_pkg;

  localparam logic        RstEnable = 1'b1;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam logic [31:0] EXC_INT      = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL  = 32'h0000_0008;
  localparam logic [31:0] EXC_BREAK    = 32'h0000_0009;
  localparam logic [31:0] EXC_INVALID  = 32'h0000_000a;
  localparam logic [31:0] EXC_OVERFLOW = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP     = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET     = 32'h0000_000e;

  localparam logic [31:0] VEC_INT = 32'h0000_0020;
  localparam logic [31:0] VEC_EXC = 32'h0000_0040;

  function automatic logic [31:0] exc_target(input logic [31:0] code, input logic [31:0] epc);
    logic [31:0] tgt;
    case (code)
      EXC_INT:                                       tgt = VEC_INT;
      EXC_SYSCALL, EXC_BREAK, EXC_INVALID,
      EXC_OVERFLOW, EXC_TRAP:                        tgt = VEC_EXC;
      EXC_ERET:                                      tgt = epc;
      default:                                       tgt = VEC_EXC;
    endcase
    return tgt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_perf.sv
// pipe_ctrl_perf: free-running stall-cycle and flush-cycle counters (wrap modulo width).
`default_nettype none

module pipe_ctrl_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_active,
  input  logic        flush_active,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
);
  import pipe_ctrl_pkg::*;

  logic [31:0] stall_cycles_q;
  logic [15:0] flush_count_q;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (stall_active) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (flush_active) flush_count_q  <= flush_count_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush arbiter with stall watchdog.
// Optional perf counters under PIPE_CTRL_PERF_EN (outputs tied to 0 otherwise).
`default_nettype none

module pipe_ctrl #(
  parameter int unsigned STALL_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [1:0]  ctrl_state,
  output logic        stall_timeout,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
);
  import pipe_ctrl_pkg::*;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(STALL_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] stall_run_q, stall_run_d;
  logic       timeout_q, timeout_d;
  logic       exc, any_req;

  assign exc     = (excepttype != ZeroWord);
  assign any_req = stallreq_if | stallreq_id | stallreq_ex | stallreq_mem;

  // Outputs are forced quiet while reset is held so nothing leaks into the pipe.
  always_comb begin
    stall  = STALL_NONE;
    flush  = 1'b0;
    new_pc = ZeroWord;
    if (rst != RstEnable) begin
      if (exc) begin
        flush  = 1'b1;
        new_pc = exc_target(excepttype, cp0_epc);
      end else if (stallreq_mem) begin
        stall = STALL_MEM;
      end else if (stallreq_ex) begin
        stall = STALL_EX;
      end else if (stallreq_id || stallreq_if) begin
        stall = STALL_ID;
      end
    end
  end

  always_comb begin
    state_d     = ST_RUN;
    stall_run_d = 8'd0;
    if (exc) begin
      state_d = ST_FLUSH;
    end else if (any_req) begin
      state_d     = ST_STALL;
      stall_run_d = (stall_run_q == 8'hFF) ? stall_run_q : stall_run_q + 8'd1;
    end
    timeout_d = timeout_q | (stall_run_d == TIMEOUT_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q     <= ST_RUN;
      stall_run_q <= 8'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_run_q <= stall_run_d;
      timeout_q   <= timeout_d;
    end
  end

  assign ctrl_state    = state_q;
  assign stall_timeout = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
  pipe_ctrl_perf u_perf (
    .clk          (clk),
    .rst          (rst),
    .stall_active (stall != STALL_NONE),
    .flush_active (flush),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vectors with hand-computed expectations for pipe_ctrl (STALL_TIMEOUT=4).
`default_nettype none

module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic [31:0] excepttype, cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [1:0]  ctrl_state;
  logic        stall_timeout;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;

  int n_vec = 0;
  int n_err = 0;

  pipe_ctrl #(.STALL_TIMEOUT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_if   (stallreq_if),
    .stallreq_id   (stallreq_id),
    .stallreq_ex   (stallreq_ex),
    .stallreq_mem  (stallreq_mem),
    .excepttype    (excepttype),
    .cp0_epc       (cp0_epc),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .ctrl_state    (ctrl_state),
    .stall_timeout (stall_timeout),
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // req = {mem, ex, id, if}; settles combinational outputs before returning
  task automatic drv(input logic [3:0] req, input logic [31:0] exc, input logic [31:0] epc);
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = req;
    excepttype = exc;
    cp0_epc    = epc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] codes [5] = '{32'h1, 32'h8, 32'hd, 32'h3, 32'hc};
  logic [31:0] pcs   [5] = '{32'h20, 32'h40, 32'h40, 32'h40, 32'h40};

  initial begin
    // reset with every input active: outputs quiet
    rst = 1'b1;
    drv(4'b1111, 32'he, 32'h55);
    chk("rst_stall", {26'd0, stall}, 32'h0);
    chk("rst_flush", {31'd0, flush}, 32'h0);
    chk("rst_newpc", new_pc, 32'h0);
    tick();
    chk("rst_state", {30'd0, ctrl_state}, 32'd0);
    chk("rst_tmo", {31'd0, stall_timeout}, 32'd0);
    chk("rst_perf_s", stall_cycles, 32'd0);
    chk("rst_perf_f", {16'd0, flush_count}, 32'd0);

    rst = 1'b0;
    drv(4'b0000, 32'h0, 32'h0);
    chk("idle_stall", {26'd0, stall}, 32'h0);
    tick();
    chk("idle_state", {30'd0, ctrl_state}, 32'd0);

    // id stall for 3 cycles, then release
    for (int i = 0; i < 3; i++) begin
      drv(4'b0010, 32'h0, 32'h0);
      chk("id_stall", {26'd0, stall}, 32'h07);
      tick();
      chk("id_state", {30'd0, ctrl_state}, 32'd1);
    end
    drv(4'b0000, 32'h0, 32'h0);
    chk("id_rel_stall", {26'd0, stall}, 32'h0);
    tick();
    chk("id_rel_state", {30'd0, ctrl_state}, 32'd0);

    drv(4'b0101, 32'h0, 32'h0);
    chk("ex_if_stall", {26'd0, stall}, 32'h0f);
    drv(4'b1000, 32'h0, 32'h0);
    chk("mem_stall", {26'd0, stall}, 32'h1f);
    drv(4'b0001, 32'h0, 32'h0);
    chk("if_stall", {26'd0, stall}, 32'h07);
    drv(4'b0000, 32'h0, 32'h0);
    tick();

    // exception code -> redirect target table
    for (int i = 0; i < 5; i++) begin
      drv(4'b0000, codes[i], 32'hdead);
      chk("exc_flush", {31'd0, flush}, 32'd1);
      chk("exc_newpc", new_pc, pcs[i]);
      tick();
    end

    // eret with mem stall pending: flush wins
    drv(4'b1000, 32'he, 32'h1234);
    chk("eret_flush", {31'd0, flush}, 32'd1);
    chk("eret_stall", {26'd0, stall}, 32'h0);
    chk("eret_newpc", new_pc, 32'h1234);
    tick();
    chk("eret_state", {30'd0, ctrl_state}, 32'd2);

    // exception while already in FLUSH
    drv(4'b0010, 32'h1, 32'h0);
    chk("ff_flush", {31'd0, flush}, 32'd1);
    chk("ff_stall", {26'd0, stall}, 32'h0);
    tick();
    chk("ff_state", {30'd0, ctrl_state}, 32'd2);
    drv(4'b0000, 32'h0, 32'h0);
    chk("noexc_newpc", new_pc, 32'h0);
    tick();
    chk("flush_1cyc", {30'd0, ctrl_state}, 32'd0);

    // reset in cycle 2 of a stall aborts it
    drv(4'b1000, 32'h0, 32'h0);
    tick();
    rst = 1'b1;
    drv(4'b1000, 32'h0, 32'h0);
    chk("midrst_stall", {26'd0, stall}, 32'h0);
    tick();
    chk("midrst_state", {30'd0, ctrl_state}, 32'd0);
    chk("midrst_tmo", {31'd0, stall_timeout}, 32'd0);
    rst = 1'b0;
    drv(4'b0000, 32'h0, 32'h0);
    tick();
    chk("postrst_state", {30'd0, ctrl_state}, 32'd0);

    // watchdog: limit 4, mem held 6 cycles
    for (int i = 1; i <= 6; i++) begin
      drv(4'b1000, 32'h0, 32'h0);
      tick();
      chk("tmo_edge", {31'd0, stall_timeout}, (i >= 4) ? 32'd1 : 32'd0);
    end
    drv(4'b0000, 32'h0, 32'h0);
    tick();
    chk("tmo_sticky", {31'd0, stall_timeout}, 32'd1);

    // perf counters: 5 stall cycles, 2 exceptions
    rst = 1'b1;
    drv(4'b0000, 32'h0, 32'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drv(4'b0010, 32'h0, 32'h0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drv(4'b0000, 32'h8, 32'h0);
      tick();
    end
    drv(4'b0000, 32'h0, 32'h0);
    tick();
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_stall", stall_cycles, 32'd5);
    chk("perf_flush", {16'd0, flush_count}, 32'd2);
`else
    chk("perf_stall_tied", stall_cycles, 32'd0);
    chk("perf_flush_tied", {16'd0, flush_count}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
